bpd2: RTL and testbench
=======================

BPD2 -- requirements
Module: bpd2

Interface
REQ-001 GHR_W, 12: global history width; global PHT and choice table hold 2^GHR_W entries each.
REQ-002 LHR_W, 10: local history width; local PHT holds 2^LHR_W entries.
REQ-003 GCNT_W / LCNT_W / CCNT_W, 2 / 3 / 2: counter widths of the global, local and choice tables.
REQ-004 PC_W, 64: program counter width; table index bits are taken from PC[GHR_W+1:2].
REQ-005 clock  in  1  the single clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  reset, synchronous and active-low.
REQ-007 req_valid_i  in  1  F1 lookup request.
REQ-008 req_pc_i, req_pc_t_i, req_pc_nt_i  in  PC_W each  fetch PC, taken target, fall-through PC.
REQ-009 req_lochist_i  in  LHR_W  local history of the fetched branch.
REQ-010 req_cond_br_i, req_btb_dir_i  in  1 each  branch is conditional; BTB predicted direction.
REQ-011 rt_valid_i  in  1  retire update strobe.
REQ-012 rt_pc_i  in  PC_W; rt_bhr_i  in  GHR_W; rt_lochist_i  in  LHR_W  snapshots of the retiring branch.
REQ-013 rt_dir_i, rt_gpred_i, rt_lpred_i  in  1 each  actual direction, global prediction, local prediction.
REQ-014 flush_i  in  1; flush_bhr_i  in  GHR_W  pipeline flush and the repaired history.
REQ-015 ready_o  out  1  table initialisation done; lookups are accepted.
REQ-016 pred_valid_o, pred_dir_o, pred_gpred_o, pred_lpred_o  out  1 each  registered prediction result.
REQ-017 pred_bhr_o  out  GHR_W  global history used for the lookup (snapshot for retire).
REQ-018 override_o  out  1; override_pc_o  out  PC_W  redirect request and redirect target.

Function
REQ-019 FSM states INIT and RUN; reset enters INIT with index counter 0.
REQ-020 INIT: each cycle, write entry [idx] of every table (local table: idx modulo 2^LHR_W) to its initial value; idx increments.
REQ-021 Initial values: global 01, local 011, choice 01 (weak local); generalised as MSB=0 with all other bits 1.
REQ-022 INIT ends after 2^max(GHR_W,LHR_W) cycles, then RUN; ready_o is high only in RUN.
REQ-023 INIT: req_valid_i, rt_valid_i and flush_i are ignored.
REQ-024 Lookup: accepted when req_valid_i && ready_o; results are registered with exactly 1 cycle of latency.
REQ-025 Indices: gidx = pc[GHR_W+1:2] ^ bhr; cidx = pc[GHR_W+1:2]; lidx = req_lochist_i.
REQ-026 gpred and lpred are the counter MSBs; pred_dir_o = choice MSB ? gpred : lpred.
REQ-027 override_o = pred_valid_o & cond & (btb_dir ^ pred_dir_o); override_pc_o = pred_dir_o ? pc_t : pc_nt.
REQ-028 Non-conditional request: pred_valid_o=1, override_o=0; bhr and tables are unchanged.
REQ-029 Speculative history: an accepted conditional request shifts bhr <= {bhr[GHR_W-2:0], predicted dir} in the response cycle.
REQ-030 Flush: bhr <= flush_bhr_i; clears the pending pred_valid_o; flush wins over a simultaneous speculative shift.
REQ-031 Retire: global[rt_pc^rt_bhr] and local[rt_lochist] count toward rt_dir_i.
REQ-032 Choice[rt_pc] is updated only when rt_gpred!=rt_lpred: +1 if rt_gpred==rt_dir, else -1.
REQ-033 Counters saturate: never wrap past all-ones or zero.
REQ-034 A same-cycle read and retire write to the same entry: the read returns the pre-write value; the write is not lost.
REQ-035 Retire and flush in the same cycle are both performed.

Reset
REQ-036 reset_n low at a clock edge: bhr=0, pred_valid_o=0, override_o=0, pred_dir_o=0, pred_gpred_o=0, pred_lpred_o=0, pred_bhr_o=0, override_pc_o=0, ready_o=0, state=INIT, idx=0.
REQ-037 reset_n asserted mid-RUN or mid-INIT restarts the full initialisation sweep.

Verification
REQ-038 Release reset with defaults -> ready_o low for 4096 cycles, then high; a request in that window gives pred_valid_o=0.
REQ-039 After init, cond request pc=0x1000, btb_dir=1 -> next cycle pred_dir_o=0 (weak local), override_o=1, override_pc_o=pc_nt, pred_bhr_o=0; bhr becomes 0.
REQ-040 Retire pc=0x1000, bhr=0, dir=1, twice -> a fresh lookup returns pred_gpred_o=1; a 3rd and 4th retire leave the counter at 11.
REQ-041 Retire with gpred=1, lpred=0, dir=1 -> choice[0x400] goes 01->10; the next lookup selects global.
REQ-042 Flush with flush_bhr=0xABC on the same cycle as an accepted cond request -> bhr=0xABC, pred_valid_o=0.
REQ-043 Assert reset_n low for 1 cycle mid-RUN -> ready_o drops, all outputs reset, and the entries trained in REQ-040 return to their initial values after the sweep.

Source files
------------

// File: rtl/bpd2.sv
// Tournament branch predictor: gshare global table, local-history table and a
// per-PC choice table, with a power-up sweep that seeds every counter.
module bpd2 #(
  parameter int GHR_W  = 12,
  parameter int LHR_W  = 10,
  parameter int GCNT_W = 2,
  parameter int LCNT_W = 3,
  parameter int CCNT_W = 2,
  parameter int PC_W   = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid_i,
  input  logic [PC_W-1:0]   req_pc_i,
  input  logic [PC_W-1:0]   req_pc_t_i,
  input  logic [PC_W-1:0]   req_pc_nt_i,
  input  logic [LHR_W-1:0]  req_lochist_i,
  input  logic              req_cond_br_i,
  input  logic              req_btb_dir_i,
  input  logic              rt_valid_i,
  input  logic [PC_W-1:0]   rt_pc_i,
  input  logic [GHR_W-1:0]  rt_bhr_i,
  input  logic [LHR_W-1:0]  rt_lochist_i,
  input  logic              rt_dir_i,
  input  logic              rt_gpred_i,
  input  logic              rt_lpred_i,
  input  logic              flush_i,
  input  logic [GHR_W-1:0]  flush_bhr_i,
  output logic              ready_o,
  output logic              pred_valid_o,
  output logic              pred_dir_o,
  output logic              pred_gpred_o,
  output logic              pred_lpred_o,
  output logic [GHR_W-1:0]  pred_bhr_o,
  output logic              override_o,
  output logic [PC_W-1:0]   override_pc_o
);

  localparam int IDX_W   = (GHR_W > LHR_W) ? GHR_W : LHR_W;
  localparam int G_DEPTH = 1 << GHR_W;
  localparam int L_DEPTH = 1 << LHR_W;

  // Weakly-not-taken seed: MSB clear, every other bit set.
  localparam logic [GCNT_W-1:0] G_INIT = {1'b0, {(GCNT_W-1){1'b1}}};
  localparam logic [LCNT_W-1:0] L_INIT = {1'b0, {(LCNT_W-1){1'b1}}};
  localparam logic [CCNT_W-1:0] C_INIT = {1'b0, {(CCNT_W-1){1'b1}}};
  localparam logic [GCNT_W-1:0] G_ONE  = GCNT_W'(1);
  localparam logic [LCNT_W-1:0] L_ONE  = LCNT_W'(1);
  localparam logic [CCNT_W-1:0] C_ONE  = CCNT_W'(1);
  localparam logic [IDX_W-1:0]  I_ONE  = IDX_W'(1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  logic [IDX_W-1:0] r_idx;

  logic [GCNT_W-1:0] r_gpht [G_DEPTH];
  logic [LCNT_W-1:0] r_lpht [L_DEPTH];
  logic [CCNT_W-1:0] r_cpht [G_DEPTH];

  logic [GHR_W-1:0] r_bhr;
  logic             r_pred_valid;
  logic             r_pred_dir;
  logic             r_pred_gpred;
  logic             r_pred_lpred;
  logic             r_pred_cond;
  logic [GHR_W-1:0] r_pred_bhr;
  logic             r_override;
  logic [PC_W-1:0]  r_override_pc;

  logic w_ready;
  logic w_accept;
  logic w_flush;
  logic w_init_we;
  logic w_rt_we;

  // ---------------- control FSM ----------------
  assign w_ready   = (r_state == ST_RUN);
  assign w_accept  = req_valid_i & w_ready;
  assign w_flush   = flush_i & w_ready;
  assign w_init_we = reset_n & (r_state == ST_INIT);
  assign w_rt_we   = reset_n & w_ready & rt_valid_i;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_idx <= r_idx + I_ONE;
    end
  end

  // NOTE: defaults come first in every always_comb so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (&r_idx) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // ---------------- lookup read port ----------------
  logic [GHR_W-1:0]  w_lk_gidx;
  logic [GHR_W-1:0]  w_lk_cidx;
  logic [GCNT_W-1:0] w_lk_g;
  logic [LCNT_W-1:0] w_lk_l;
  logic [CCNT_W-1:0] w_lk_c;
  logic              w_lk_gpred;
  logic              w_lk_lpred;
  logic              w_lk_dir;

  assign w_lk_cidx  = req_pc_i[GHR_W+1:2];
  assign w_lk_gidx  = w_lk_cidx ^ r_bhr;
  assign w_lk_g     = r_gpht[w_lk_gidx];
  assign w_lk_l     = r_lpht[req_lochist_i];
  assign w_lk_c     = r_cpht[w_lk_cidx];
  assign w_lk_gpred = w_lk_g[GCNT_W-1];
  assign w_lk_lpred = w_lk_l[LCNT_W-1];
  assign w_lk_dir   = w_lk_c[CCNT_W-1] ? w_lk_gpred : w_lk_lpred;

  // ---------------- retire read-modify-write ----------------
  logic [GHR_W-1:0]  w_rt_cidx;
  logic [GHR_W-1:0]  w_rt_gidx;
  logic [GCNT_W-1:0] w_rt_g;
  logic [LCNT_W-1:0] w_rt_l;
  logic [CCNT_W-1:0] w_rt_c;
  logic [GCNT_W-1:0] w_rt_g_nxt;
  logic [LCNT_W-1:0] w_rt_l_nxt;
  logic [CCNT_W-1:0] w_rt_c_nxt;
  logic              w_rt_c_we;
  logic              w_rt_c_up;

  assign w_rt_cidx = rt_pc_i[GHR_W+1:2];
  assign w_rt_gidx = w_rt_cidx ^ rt_bhr_i;
  assign w_rt_g    = r_gpht[w_rt_gidx];
  assign w_rt_l    = r_lpht[rt_lochist_i];
  assign w_rt_c    = r_cpht[w_rt_cidx];
  assign w_rt_c_we = rt_gpred_i ^ rt_lpred_i;
  assign w_rt_c_up = (rt_gpred_i == rt_dir_i);

  // Saturating step: hold at all-ones when counting up, at zero when counting down.
  always_comb begin
    w_rt_g_nxt = w_rt_g;
    w_rt_l_nxt = w_rt_l;
    w_rt_c_nxt = w_rt_c;
    if (rt_dir_i) begin
      if (!(&w_rt_g)) w_rt_g_nxt = w_rt_g + G_ONE;
      if (!(&w_rt_l)) w_rt_l_nxt = w_rt_l + L_ONE;
    end else begin
      if (|w_rt_g) w_rt_g_nxt = w_rt_g - G_ONE;
      if (|w_rt_l) w_rt_l_nxt = w_rt_l - L_ONE;
    end
    if (w_rt_c_up) begin
      if (!(&w_rt_c)) w_rt_c_nxt = w_rt_c + C_ONE;
    end else begin
      if (|w_rt_c) w_rt_c_nxt = w_rt_c - C_ONE;
    end
  end

  // NOTE: the tables carry no reset branch; the INIT sweep seeds every entry,
  // so the arrays stay mappable onto plain RAM.
  always_ff @(posedge clock) begin
    if (w_init_we) begin
      r_gpht[r_idx[GHR_W-1:0]] <= G_INIT;
      r_cpht[r_idx[GHR_W-1:0]] <= C_INIT;
      r_lpht[r_idx[LHR_W-1:0]] <= L_INIT;
    end else if (w_rt_we) begin
      r_gpht[w_rt_gidx]    <= w_rt_g_nxt;
      r_lpht[rt_lochist_i] <= w_rt_l_nxt;
      if (w_rt_c_we) r_cpht[w_rt_cidx] <= w_rt_c_nxt;
    end
  end

  // ---------------- global history ----------------
  // A repair from flush always beats the speculative shift of a live response.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_bhr <= '0;
    end else if (w_flush) begin
      r_bhr <= flush_bhr_i;
    end else if (r_pred_valid && r_pred_cond) begin
      r_bhr <= {r_bhr[GHR_W-2:0], r_pred_dir};
    end
  end

  // ---------------- registered response ----------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pred_valid  <= 1'b0;
      r_pred_dir    <= 1'b0;
      r_pred_gpred  <= 1'b0;
      r_pred_lpred  <= 1'b0;
      r_pred_cond   <= 1'b0;
      r_pred_bhr    <= '0;
      r_override    <= 1'b0;
      r_override_pc <= '0;
    end else begin
      r_pred_valid <= w_accept & ~w_flush;
      if (w_accept) begin
        r_pred_dir    <= w_lk_dir;
        r_pred_gpred  <= w_lk_gpred;
        r_pred_lpred  <= w_lk_lpred;
        r_pred_cond   <= req_cond_br_i;
        r_pred_bhr    <= r_bhr;
        r_override    <= req_cond_br_i & (req_btb_dir_i ^ w_lk_dir);
        r_override_pc <= w_lk_dir ? req_pc_t_i : req_pc_nt_i;
      end
    end
  end

  assign ready_o       = w_ready;
  assign pred_valid_o  = r_pred_valid;
  assign pred_dir_o    = r_pred_dir;
  assign pred_gpred_o  = r_pred_gpred;
  assign pred_lpred_o  = r_pred_lpred;
  assign pred_bhr_o    = r_pred_bhr;
  assign override_o    = r_pred_valid & r_override;
  assign override_pc_o = r_override_pc;

  // PC bits outside the table index never reach the tables.
  logic w_unused;
  assign w_unused = ^{req_pc_i[PC_W-1:GHR_W+2], req_pc_i[1:0],
                      rt_pc_i[PC_W-1:GHR_W+2], rt_pc_i[1:0]};

endmodule

// File: tb/tb_bpd2.sv
// Self-checking bench for bpd2: a table-level reference model compared every
// cycle, plus hand-computed checks of the key scenarios.
module tb_bpd2;

  localparam int GW = 12;
  localparam int LW = 10;

  logic          clock;
  logic          reset_n;
  logic          req_valid_i;
  logic [63:0]   req_pc_i, req_pc_t_i, req_pc_nt_i;
  logic [LW-1:0] req_lochist_i;
  logic          req_cond_br_i, req_btb_dir_i;
  logic          rt_valid_i;
  logic [63:0]   rt_pc_i;
  logic [GW-1:0] rt_bhr_i;
  logic [LW-1:0] rt_lochist_i;
  logic          rt_dir_i, rt_gpred_i, rt_lpred_i;
  logic          flush_i;
  logic [GW-1:0] flush_bhr_i;
  logic          ready_o, pred_valid_o, pred_dir_o, pred_gpred_o, pred_lpred_o;
  logic [GW-1:0] pred_bhr_o;
  logic          override_o;
  logic [63:0]   override_pc_o;

  bpd2 dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_pc_i(req_pc_i), .req_pc_t_i(req_pc_t_i),
    .req_pc_nt_i(req_pc_nt_i), .req_lochist_i(req_lochist_i),
    .req_cond_br_i(req_cond_br_i), .req_btb_dir_i(req_btb_dir_i),
    .rt_valid_i(rt_valid_i), .rt_pc_i(rt_pc_i), .rt_bhr_i(rt_bhr_i),
    .rt_lochist_i(rt_lochist_i), .rt_dir_i(rt_dir_i), .rt_gpred_i(rt_gpred_i),
    .rt_lpred_i(rt_lpred_i), .flush_i(flush_i), .flush_bhr_i(flush_bhr_i),
    .ready_o(ready_o), .pred_valid_o(pred_valid_o), .pred_dir_o(pred_dir_o),
    .pred_gpred_o(pred_gpred_o), .pred_lpred_o(pred_lpred_o),
    .pred_bhr_o(pred_bhr_o), .override_o(override_o), .override_pc_o(override_pc_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_run;
  int n_fail;
  bit cmp_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int        gt [4096];
  int        lt [1024];
  int        ct [4096];
  bit        m_ready;
  int        m_cnt;
  bit [11:0] m_bhr;
  bit        e_valid, e_dir, e_g, e_l, e_ovr, e_cond;
  bit [11:0] e_bhr;
  bit [63:0] e_opc;

  always @(posedge clock) begin : model
    bit [11:0] nb, gi, ci;
    bit [9:0]  li;
    if (!reset_n) begin
      m_ready = 0; m_cnt = 0; m_bhr = '0;
      e_valid = 0; e_dir = 0; e_g = 0; e_l = 0; e_ovr = 0; e_cond = 0;
      e_bhr = '0; e_opc = '0;
    end else if (!m_ready) begin
      e_valid = 0;
      m_cnt++;
      if (m_cnt == 4096) begin
        m_ready = 1;
        foreach (gt[i]) gt[i] = 1;
        foreach (ct[i]) ct[i] = 1;
        foreach (lt[i]) lt[i] = 3;
      end
    end else begin
      nb = m_bhr;
      if (e_valid && e_cond) nb = {m_bhr[10:0], e_dir};
      if (req_valid_i) begin
        ci = req_pc_i[13:2];
        gi = ci ^ m_bhr;
        li = req_lochist_i;
        e_g    = gt[gi] >= 2;
        e_l    = lt[li] >= 4;
        e_dir  = (ct[ci] >= 2) ? e_g : e_l;
        e_cond = req_cond_br_i;
        e_ovr  = req_cond_br_i && (req_btb_dir_i != e_dir);
        e_opc  = e_dir ? req_pc_t_i : req_pc_nt_i;
        e_bhr  = m_bhr;
      end
      e_valid = req_valid_i && !flush_i;
      if (flush_i) nb = flush_bhr_i;
      if (rt_valid_i) begin
        ci = rt_pc_i[13:2];
        gi = ci ^ rt_bhr_i;
        li = rt_lochist_i;
        gt[gi] = rt_dir_i ? ((gt[gi] < 3) ? gt[gi] + 1 : 3) : ((gt[gi] > 0) ? gt[gi] - 1 : 0);
        lt[li] = rt_dir_i ? ((lt[li] < 7) ? lt[li] + 1 : 7) : ((lt[li] > 0) ? lt[li] - 1 : 0);
        if (rt_gpred_i != rt_lpred_i)
          ct[ci] = (rt_gpred_i == rt_dir_i) ? ((ct[ci] < 3) ? ct[ci] + 1 : 3)
                                           : ((ct[ci] > 0) ? ct[ci] - 1 : 0);
      end
      m_bhr = nb;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clock) begin
    if (cmp_en) begin
      check("ready", ready_o, m_ready);
      check("pred_valid", pred_valid_o, e_valid);
      check("override", override_o, e_valid & e_ovr);
      if (e_valid || !m_ready) begin
        check("pred_dir", pred_dir_o, e_dir);
        check("pred_gpred", pred_gpred_o, e_g);
        check("pred_lpred", pred_lpred_o, e_l);
        check("pred_bhr", pred_bhr_o, e_bhr);
        check("override_pc", override_pc_o, e_opc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
    req_valid_i = 0; rt_valid_i = 0; flush_i = 0;
  endtask

  task automatic lookup(input logic [63:0] pc, input logic [LW-1:0] lh, input logic cond, input logic btb);
    req_valid_i = 1; req_pc_i = pc; req_pc_t_i = pc + 64'h1000; req_pc_nt_i = pc + 64'h4;
    req_lochist_i = lh; req_cond_br_i = cond; req_btb_dir_i = btb;
  endtask

  task automatic retire(input logic [63:0] pc, input logic [GW-1:0] bhr, input logic [LW-1:0] lh,
                        input logic dir, input logic g, input logic l);
    rt_valid_i = 1; rt_pc_i = pc; rt_bhr_i = bhr; rt_lochist_i = lh;
    rt_dir_i = dir; rt_gpred_i = g; rt_lpred_i = l;
  endtask

  // Counts edges until ready_o rises; pokes ignored traffic into the window if asked.
  task automatic wait_ready(input string name, input bit poke);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clock);
      cnt++;
      #1;
      if (poke && cnt == 10) begin
        lookup(64'h1000, '0, 1'b1, 1'b1);
        flush_i = 1; flush_bhr_i = 12'h555;
        retire(64'h1000, '0, '0, 1'b1, 1'b1, 1'b0);
      end
      if (poke && cnt == 11) begin
        req_valid_i = 0; rt_valid_i = 0; flush_i = 0;
        check("init_req_ignored", pred_valid_o, 1'b0);
      end
      if (ready_o) break;
    end
    check(name, cnt, 4096);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_run = 0; n_fail = 0; cmp_en = 0;
    reset_n = 0;
    req_valid_i = 0; req_pc_i = '0; req_pc_t_i = '0; req_pc_nt_i = '0; req_lochist_i = '0;
    req_cond_br_i = 0; req_btb_dir_i = 0;
    rt_valid_i = 0; rt_pc_i = '0; rt_bhr_i = '0; rt_lochist_i = '0;
    rt_dir_i = 0; rt_gpred_i = 0; rt_lpred_i = 0;
    flush_i = 0; flush_bhr_i = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    cmp_en = 1;
    check("rst_ready", ready_o, 1'b0);
    check("rst_valid", pred_valid_o, 1'b0);
    check("rst_override_pc", override_pc_o, 64'h0);
    reset_n = 1;
    wait_ready("init_cycles", 1'b1);

    // First conditional lookup: weak local predicts not-taken, BTB says taken.
    lookup(64'h1000, 10'h000, 1'b1, 1'b1);
    step();
    check("l1_valid", pred_valid_o, 1'b1);
    check("l1_dir", pred_dir_o, 1'b0);
    check("l1_override", override_o, 1'b1);
    check("l1_override_pc", override_pc_o, 64'h1004);
    check("l1_bhr", pred_bhr_o, 12'h000);
    step();

    // Train global[0x400] toward taken twice.
    repeat (2) begin retire(64'h1000, 12'h000, 10'h3FF, 1'b1, 1'b0, 1'b0); step(); end
    lookup(64'h1000, 10'h000, 1'b1, 1'b1);
    step();
    check("train2_gpred", pred_gpred_o, 1'b1);
    check("train2_dir_local", pred_dir_o, 1'b0);
    step();
    repeat (2) begin retire(64'h1000, 12'h000, 10'h3FF, 1'b1, 1'b0, 1'b0); step(); end
    lookup(64'h1000, 10'h000, 1'b1, 1'b1);
    step();
    check("train4_sat_hi", pred_gpred_o, 1'b1);
    step();

    // Global right, local wrong: choice moves to global.
    retire(64'h1000, 12'h000, 10'h3FF, 1'b1, 1'b1, 1'b0);
    step();
    lookup(64'h1000, 10'h000, 1'b1, 1'b1);
    step();
    check("choice_dir", pred_dir_o, 1'b1);
    check("choice_override", override_o, 1'b0);
    check("choice_override_pc", override_pc_o, 64'h2000);
    step();
    lookup(64'h1000, 10'h3FF, 1'b0, 1'b1);
    step();
    check("shift_bhr", pred_bhr_o, 12'h001);
    check("local_sat_lpred", pred_lpred_o, 1'b1);
    check("noncond_override", override_o, 1'b0);
    step();

    // Same-cycle lookup and retire to global[0x801].
    lookup(64'h2000, 10'h000, 1'b0, 1'b0);
    retire(64'h2000, 12'h001, 10'h010, 1'b1, 1'b0, 1'b0);
    step();
    check("rd_before_wr", pred_gpred_o, 1'b0);
    lookup(64'h2000, 10'h000, 1'b0, 1'b0);
    step();
    check("wr_kept", pred_gpred_o, 1'b1);
    step();

    // Flush together with an accepted request and a retire.
    lookup(64'h1000, 10'h000, 1'b1, 1'b1);
    flush_i = 1; flush_bhr_i = 12'hABC;
    retire(64'h3000, 12'h000, 10'h000, 1'b0, 1'b0, 1'b0);
    step();
    check("flush_kills_valid", pred_valid_o, 1'b0);
    lookup(64'h3000, 10'h000, 1'b0, 1'b0);
    step();
    check("flush_bhr", pred_bhr_o, 12'hABC);
    step();

    // Flush during a conditional response wins over the speculative shift.
    lookup(64'h1000, 10'h000, 1'b1, 1'b1);
    step();
    flush_i = 1; flush_bhr_i = 12'h123;
    step();
    lookup(64'h1000, 10'h000, 1'b0, 1'b0);
    step();
    check("flush_wins", pred_bhr_o, 12'h123);
    step();

    // Drive counters to the floor; choice decrements toward local.
    repeat (3) begin retire(64'h3000, 12'h123, 10'h000, 1'b0, 1'b1, 1'b0); step(); end
    lookup(64'h3000, 10'h000, 1'b1, 1'b1);
    step();
    check("sat_lo_gpred", pred_gpred_o, 1'b0);
    check("sat_lo_lpred", pred_lpred_o, 1'b0);
    check("sat_lo_override", override_o, 1'b1);
    step();

    // Mid-run reset restarts the sweep and restores trained entries.
    reset_n = 0;
    step();
    check("rst2_ready", ready_o, 1'b0);
    check("rst2_valid", pred_valid_o, 1'b0);
    check("rst2_bhr", pred_bhr_o, 12'h000);
    check("rst2_override_pc", override_pc_o, 64'h0);
    reset_n = 1;
    wait_ready("reinit_cycles", 1'b0);
    lookup(64'h1000, 10'h3FF, 1'b1, 1'b1);
    step();
    check("reinit_gpred", pred_gpred_o, 1'b0);
    check("reinit_lpred", pred_lpred_o, 1'b0);
    check("reinit_dir", pred_dir_o, 1'b0);
    check("reinit_override", override_o, 1'b1);
    repeat (3) step();

    @(negedge clock);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
